// File: rtl/inst_word_assembler.sv
// rtl/inst_word_assembler.sv - pairs AVR instruction words into complete 16/32-bit instructions for decode
module inst_word_assembler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         ireset,
    input  logic [W-1:0] imem_data,
    input  logic         imem_valid,
    input  logic [W-1:0] pc_in,
    input  logic         stall,
    input  logic         flush,
    output logic         ready,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst2,
    output logic [W-1:0] inst_pc,
    output logic         is_32,
    output logic         inst_valid,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state;
    logic   detect;

    // LDS/STS and JMP/CALL carry a second word of address or immediate
    always_comb begin
        detect = ((imem_data & W'(16'hFC0F)) == W'(16'h9000))
              || ((imem_data & W'(16'hFE0C)) == W'(16'h940C));
    end

    assign ready = (state != FULL) || !stall;

    always_ff @(posedge clk or posedge ireset) begin
        if (ireset) begin
            state      <= IDLE;
            inst       <= '0;
            inst2      <= '0;
            inst_pc    <= '0;
            is_32      <= 1'b0;
            inst_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
        end else begin
            if (imem_valid && !ready) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (imem_valid) begin
                        inst       <= imem_data;
                        inst_pc    <= pc_in;
                        is_32      <= detect;
                        state      <= detect ? HALF : FULL;
                        inst_valid <= !detect;
                    end
                end
                HALF: begin
                    if (imem_valid) begin
                        inst2      <= imem_data;
                        state      <= FULL;
                        inst_valid <= 1'b1;
                    end
                end
                FULL: begin
                    // consumed this edge; a waiting word issues back-to-back
                    if (!stall) begin
                        if (imem_valid) begin
                            inst       <= imem_data;
                            inst_pc    <= pc_in;
                            is_32      <= detect;
                            state      <= detect ? HALF : FULL;
                            inst_valid <= !detect;
                        end else begin
                            state      <= IDLE;
                            inst_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_word_assembler.sv
// tb/tb_inst_word_assembler.sv - directed self-checking bench for inst_word_assembler
module tb_inst_word_assembler;

    logic        clk = 1'b0;
    logic        ireset;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] pc_in;
    logic        stall;
    logic        flush;
    logic        ready;
    logic [15:0] inst;
    logic [15:0] inst2;
    logic [15:0] inst_pc;
    logic        is_32;
    logic        inst_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    inst_word_assembler #(.W(16)) dut (
        .clk        (clk),
        .ireset     (ireset),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .pc_in      (pc_in),
        .stall      (stall),
        .flush      (flush),
        .ready      (ready),
        .inst       (inst),
        .inst2      (inst2),
        .inst_pc    (inst_pc),
        .is_32      (is_32),
        .inst_valid (inst_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] d, input logic [15:0] pc);
        imem_valid = 1'b1;
        imem_data  = d;
        pc_in      = pc;
    endtask

    logic [15:0] ops  [3];
    logic [15:0] last2;

    initial begin
        ireset = 1'b1; imem_data = '0; imem_valid = 1'b0; pc_in = '0;
        stall = 1'b0; flush = 1'b0;
        ops[0] = 16'h9100; ops[1] = 16'h9300; ops[2] = 16'h940C;
        last2 = '0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_ovr", overrun, 0);
        tick(); tick();
        ireset = 1'b0;

        // three back-to-back 16-bit instructions
        word(16'h0000, 16'd0); tick();
        chk("t1_v0", inst_valid, 1); chk("t1_pc0", inst_pc, 0); chk("t1_32_0", is_32, 0);
        word(16'h2C01, 16'd1); tick();
        chk("t1_v1", inst_valid, 1); chk("t1_pc1", inst_pc, 1); chk("t1_i1", inst, 16'h2C01);
        word(16'hE0F5, 16'd2); tick();
        chk("t1_v2", inst_valid, 1); chk("t1_pc2", inst_pc, 2); chk("t1_32_2", is_32, 0);
        imem_valid = 1'b0; tick();
        chk("t1_idle", inst_valid, 0);

        // CALL with a two-cycle gap before the second word
        word(16'h940E, 16'h0010); tick();
        chk("call_half", inst_valid, 0);
        imem_valid = 1'b0; tick(); tick();
        chk("call_gap", inst_valid, 0);
        word(16'h1234, 16'h0011); tick();
        chk("call_v", inst_valid, 1); chk("call_i", inst, 16'h940E);
        chk("call_i2", inst2, 16'h1234); chk("call_pc", inst_pc, 16'h0010);
        chk("call_32", is_32, 1);
        imem_valid = 1'b0; tick();

        for (int i = 0; i < 3; i++) begin
            word(ops[i], 16'h0040 + 16'(i * 2)); tick();
            chk("op_half", inst_valid, 0);
            last2 = 16'hA000 + 16'(i);
            word(last2, 16'h0041 + 16'(i * 2)); tick();
            chk("op_v", inst_valid, 1); chk("op_i", inst, ops[i]);
            chk("op_i2", inst2, last2); chk("op_32", is_32, 1);
            imem_valid = 1'b0; tick();
        end

        word(16'h9400, 16'h0050); tick();
        chk("9400_v", inst_valid, 1); chk("9400_32", is_32, 0);
        imem_valid = 1'b0; tick();

        // stall holds FULL; release with a new word issues without a bubble
        word(16'h2C01, 16'd4); tick();
        imem_valid = 1'b0; stall = 1'b1; #1;
        chk("st_ready", ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_v", inst_valid, 1); chk("st_pc", inst_pc, 4); chk("st_i", inst, 16'h2C01);
            chk("st_ready_h", ready, 0);
        end
        chk("st_ovr", overrun, 0);
        stall = 1'b0; word(16'h0000, 16'd5); #1;
        chk("st_rel_ready", ready, 1);
        tick();
        chk("st_rel_v", inst_valid, 1); chk("st_rel_pc", inst_pc, 5);
        imem_valid = 1'b0; tick();

        // flush in HALF drops the concurrent word
        word(16'h940E, 16'h0020); tick();
        flush = 1'b1; word(16'h1111, 16'h0021); tick();
        flush = 1'b0; imem_valid = 1'b0;
        chk("fl_v", inst_valid, 0); chk("fl_i2", inst2, last2); chk("fl_i", inst, 16'h940E);
        tick();
        chk("fl_idle", inst_valid, 0);
        word(16'h0001, 16'h0030); tick();
        chk("fl_nv", inst_valid, 1); chk("fl_ni", inst, 16'h0001);
        chk("fl_n32", is_32, 0); chk("fl_npc", inst_pc, 16'h0030); chk("fl_ni2", inst2, last2);

        // overrun: word offered while FULL and stalled
        stall = 1'b1; word(16'h5555, 16'h0031); #1;
        chk("ov_ready", ready, 0);
        tick();
        imem_valid = 1'b0;
        chk("ov_set", overrun, 1); chk("ov_i", inst, 16'h0001); chk("ov_pc", inst_pc, 16'h0030);
        tick();
        chk("ov_sticky", overrun, 1);

        // asynchronous reset mid-cycle
        #2 ireset = 1'b1; #1;
        chk("ar_v", inst_valid, 0); chk("ar_i", inst, 0); chk("ar_i2", inst2, 0);
        chk("ar_pc", inst_pc, 0); chk("ar_32", is_32, 0); chk("ar_ovr", overrun, 0);
        chk("ar_ready", ready, 1);
        tick();
        ireset = 1'b0; stall = 1'b0;
        word(16'h940C, 16'h0060); tick();
        chk("ar_first", inst_valid, 0); chk("ar_first32", is_32, 1);
        imem_valid = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
